// File: rtl/spadix_ctrl.sv
// Spadix transfer sequencer: reads words from a source bank, waits out the PE pipeline, writes results to a destination bank.
// Latency: start sampled at edge T gives RD outputs in cycle T+1; each word takes 1 RD + PE_LATENCY WAIT + 1 WR cycles, then one DONE cycle.
// Backpressure: none. start is honoured only in IDLE and is never queued; abort cancels a running job on the next edge.
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   start, abort        job request (IDLE only) / synchronous cancel (RD, WAIT, WR only)
//   cfg_*               job configuration, latched when start is accepted
//   busy, done          busy in RD/WAIT/WR; done is a one-cycle pulse in DONE
//   addrh, addrv        shared bank select and row address
//   chip_enable, write_enable, output_enable   active-low per-bank strobes
//   perf_cycles         busy-cycle count of the last completed job
//
// Optional feature: define SPADIX_CTRL_PERF_EN to build the busy-cycle counter.
// Without it, perf_cycles is tied to zero and no counter logic exists.

module spadix_ctrl #(
    parameter int SRAM_BANK  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int PE_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            cfg_src_bank,
    input  logic [2:0]            cfg_dst_bank,
    input  logic [ADDR_WIDTH-1:0] cfg_base_rd,
    input  logic [ADDR_WIDTH-1:0] cfg_base_wr,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            addrh,
    output logic [ADDR_WIDTH-1:0] addrv,
    output logic [SRAM_BANK-1:0]  chip_enable,
    output logic [SRAM_BANK-1:0]  write_enable,
    output logic [SRAM_BANK-1:0]  output_enable,
    output logic [15:0]           perf_cycles
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // ---------------------------------------------------------------
    // State and latched job configuration
    // ---------------------------------------------------------------
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_i;
    logic [3:0]            r_wcnt;
    logic [2:0]            r_src;
    logic [2:0]            r_dst;
    logic [ADDR_WIDTH-1:0] r_base_rd;
    logic [ADDR_WIDTH-1:0] r_base_wr;
    logic [ADDR_WIDTH-1:0] r_len;

    // Registered outputs
    logic                  r_busy;
    logic                  r_done;
    logic [2:0]            r_addrh;
    logic [ADDR_WIDTH-1:0] r_addrv;
    logic [SRAM_BANK-1:0]  r_ce;
    logic [SRAM_BANK-1:0]  r_we;
    logic [SRAM_BANK-1:0]  r_oe;

    // Next-state signals
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_i_nxt;
    logic [3:0]            w_wcnt_nxt;
    logic                  w_accept;

    // Configuration as seen by the next cycle: on the accept edge the
    // registers are still stale, so take the values straight from cfg_*.
    logic [2:0]            w_src;
    logic [ADDR_WIDTH-1:0] w_base_rd;
    logic [SRAM_BANK-1:0]  w_src_sel;
    logic [SRAM_BANK-1:0]  w_dst_sel;

    // Next output values
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [2:0]            w_addrh_nxt;
    logic [ADDR_WIDTH-1:0] w_addrv_nxt;
    logic [SRAM_BANK-1:0]  w_ce_nxt;
    logic [SRAM_BANK-1:0]  w_we_nxt;
    logic [SRAM_BANK-1:0]  w_oe_nxt;

    assign w_src     = w_accept ? cfg_src_bank : r_src;
    assign w_base_rd = w_accept ? cfg_base_rd  : r_base_rd;
    assign w_src_sel = SRAM_BANK'(1) << w_src;
    assign w_dst_sel = SRAM_BANK'(1) << r_dst;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_wcnt_nxt  = r_wcnt;
        w_accept    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // start outranks a simultaneous abort; abort is a no-op here anyway
                if (start) begin
                    w_accept    = 1'b1;
                    w_i_nxt     = '0;
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wcnt_nxt  = 4'(PE_LATENCY - 1);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wcnt == 4'd0) begin
                    w_state_nxt = S_WR;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            S_WR: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_i == r_len) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_i_nxt     = r_i + ADDR_WIDTH'(1);
                    w_state_nxt = S_RD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Next-output logic: outputs are a function of the state being
    // entered, so they can be registered and still line up with it.
    // ---------------------------------------------------------------
    always_comb begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_addrh_nxt = r_addrh;
        w_addrv_nxt = r_addrv;
        w_ce_nxt    = '1;
        w_we_nxt    = '1;
        w_oe_nxt    = '1;

        case (w_state_nxt)
            S_RD: begin
                w_busy_nxt  = 1'b1;
                w_addrh_nxt = w_src;
                w_addrv_nxt = w_base_rd + w_i_nxt;
                w_ce_nxt    = ~w_src_sel;
                w_oe_nxt    = ~w_src_sel;
            end
            S_WAIT: begin
                // bank select and row hold their RD values; strobes idle
                w_busy_nxt = 1'b1;
            end
            S_WR: begin
                w_busy_nxt  = 1'b1;
                w_addrh_nxt = r_dst;
                w_addrv_nxt = r_base_wr + w_i_nxt;
                w_ce_nxt    = ~w_dst_sel;
                w_we_nxt    = ~w_dst_sel;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State, configuration and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_wcnt    <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_base_rd <= '0;
            r_base_wr <= '0;
            r_len     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addrh   <= '0;
            r_addrv   <= '0;
            r_ce      <= '1;
            r_we      <= '1;
            r_oe      <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_accept) begin
                r_src     <= cfg_src_bank;
                r_dst     <= cfg_dst_bank;
                r_base_rd <= cfg_base_rd;
                r_base_wr <= cfg_base_wr;
                r_len     <= cfg_len;
            end
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_addrh <= w_addrh_nxt;
            r_addrv <= w_addrv_nxt;
            r_ce    <= w_ce_nxt;
            r_we    <= w_we_nxt;
            r_oe    <= w_oe_nxt;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign addrh         = r_addrh;
    assign addrv         = r_addrv;
    assign chip_enable   = r_ce;
    assign write_enable  = r_we;
    assign output_enable = r_oe;

    // ---------------------------------------------------------------
    // Busy-cycle counter
    // ---------------------------------------------------------------
`ifdef SPADIX_CTRL_PERF_EN
    logic [15:0] r_perf_cnt;
    logic [15:0] r_perf;
    logic [15:0] w_perf_inc;

    // r_busy mirrors "current state is RD/WAIT/WR", so it gates the count.
    assign w_perf_inc = (r_busy && (r_perf_cnt != 16'hFFFF)) ? r_perf_cnt + 16'd1
                                                               : r_perf_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_cnt <= '0;
            r_perf     <= '0;
        end else begin
            if (w_accept) begin
                r_perf_cnt <= '0;
            end else begin
                r_perf_cnt <= w_perf_inc;
            end
            // Capture includes the final WR cycle being counted on this edge.
            // An aborted job never reaches DONE, so the old value stays.
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
                r_perf <= w_perf_inc;
            end
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_spadix_ctrl.sv
// Bench for spadix_ctrl: directed jobs, a per-cycle reference model and literal spot checks.
// Latency: one DONE per completed job, (len+1)*(PE_LATENCY+2) busy cycles per job.
// Backpressure: not applicable; stimulus is driven on falling edges.

module tb_spadix_ctrl;

    localparam int NB  = 8;
    localparam int AW  = 8;
    localparam int PEL = 4;
`ifdef SPADIX_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    localparam logic [2:0] K_IDLE = 3'd0;
    localparam logic [2:0] K_RD   = 3'd1;
    localparam logic [2:0] K_WAIT = 3'd2;
    localparam logic [2:0] K_WR   = 3'd3;
    localparam logic [2:0] K_DONE = 3'd4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    cfg_src_bank = '0;
    logic [2:0]    cfg_dst_bank = '0;
    logic [AW-1:0] cfg_base_rd = '0;
    logic [AW-1:0] cfg_base_wr = '0;
    logic [AW-1:0] cfg_len = '0;
    logic          busy;
    logic          done;
    logic [2:0]    addrh;
    logic [AW-1:0] addrv;
    logic [NB-1:0] chip_enable;
    logic [NB-1:0] write_enable;
    logic [NB-1:0] output_enable;
    logic [15:0]   perf_cycles;

    int n_cmp  = 0;
    int n_fail = 0;

    spadix_ctrl #(.SRAM_BANK(NB), .ADDR_WIDTH(AW), .PE_LATENCY(PEL)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cfg_src_bank  (cfg_src_bank),
        .cfg_dst_bank  (cfg_dst_bank),
        .cfg_base_rd   (cfg_base_rd),
        .cfg_base_wr   (cfg_base_wr),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .addrh         (addrh),
        .addrv         (addrv),
        .chip_enable   (chip_enable),
        .write_enable  (write_enable),
        .output_enable (output_enable),
        .perf_cycles   (perf_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: a job expands into a list of per-cycle phases
    // (RD, PEL x WAIT, WR per word, then DONE); the DUT must walk it.
    // ---------------------------------------------------------------
    typedef struct packed {
        logic [2:0]    kind;
        logic [2:0]    ah;
        logic [AW-1:0] av;
        logic [NB-1:0] ce;
        logic [NB-1:0] we;
        logic [NB-1:0] oe;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    int   job_cycles;
    int   exp_perf;

    function automatic rec_t mk(input logic [2:0] k, input logic [2:0] ah, input logic [AW-1:0] av,
                                input logic [NB-1:0] ce, input logic [NB-1:0] we, input logic [NB-1:0] oe);
        rec_t r;
        r.kind = k; r.ah = ah; r.av = av; r.ce = ce; r.we = we; r.oe = oe;
        return r;
    endfunction

    task automatic build_job(input logic [2:0] src, input logic [2:0] dst, input logic [AW-1:0] brd,
                             input logic [AW-1:0] bwr, input logic [AW-1:0] len);
        logic [NB-1:0] ss;
        logic [NB-1:0] ds;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        ss = ~(8'b1 << src);
        ds = ~(8'b1 << dst);
        for (int w = 0; w <= int'(len); w++) begin
            ra = brd + w[AW-1:0];
            wa = bwr + w[AW-1:0];
            q.push_back(mk(K_RD, src, ra, ss, 8'hFF, ss));
            for (int k = 0; k < PEL; k++) q.push_back(mk(K_WAIT, src, ra, 8'hFF, 8'hFF, 8'hFF));
            q.push_back(mk(K_WR, dst, wa, ds, ds, 8'hFF));
        end
        q.push_back(mk(K_DONE, 3'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF));
        job_cycles = (int'(len) + 1) * (PEL + 2);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            cur      = mk(K_IDLE, 3'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF);
            exp_perf = 0;
        end else begin
            if ((cur.kind inside {K_RD, K_WAIT, K_WR}) && abort) begin
                q.delete();
                cur = mk(K_IDLE, 3'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF);
            end else if ((cur.kind == K_IDLE) && start) begin
                build_job(cfg_src_bank, cfg_dst_bank, cfg_base_rd, cfg_base_wr, cfg_len);
                cur = q.pop_front();
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = mk(K_IDLE, 3'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF);
            end
            if (cur.kind == K_DONE) exp_perf = PERF_ON ? ((job_cycles > 65535) ? 65535 : job_cycles) : 0;
        end
    end

    // Compare every cycle out of reset; addresses only matter while busy.
    always @(negedge clk) begin
        if (reset) begin
            chk("m_busy", {31'd0, busy}, {31'd0, cur.kind inside {K_RD, K_WAIT, K_WR}});
            chk("m_done", {31'd0, done}, {31'd0, cur.kind == K_DONE});
            chk("m_ce",   {24'd0, chip_enable},   {24'd0, cur.ce});
            chk("m_we",   {24'd0, write_enable},  {24'd0, cur.we});
            chk("m_oe",   {24'd0, output_enable}, {24'd0, cur.oe});
            chk("m_perf", {16'd0, perf_cycles},   exp_perf);
            if (cur.kind inside {K_RD, K_WAIT, K_WR}) begin
                chk("m_addrh", {29'd0, addrh}, {29'd0, cur.ah});
                chk("m_addrv", {24'd0, addrv}, {24'd0, cur.av});
            end
        end
    end

    // ---------------------------------------------------------------
    // Directed stimulus and literal expectations
    // ---------------------------------------------------------------
    typedef struct packed {
        logic          b;
        logic          d;
        logic [2:0]    ah;
        logic [AW-1:0] av;
        logic [NB-1:0] ce;
        logic [NB-1:0] we;
        logic [NB-1:0] oe;
    } snap_t;

    snap_t snaps[$];

    // Called on a falling edge with the DUT idle; returns on the falling
    // edge that opens the first RD cycle.
    task automatic start_job(input logic [2:0] s, input logic [2:0] d, input logic [AW-1:0] br,
                             input logic [AW-1:0] bw, input logic [AW-1:0] l, input bit with_abort);
        cfg_src_bank = s; cfg_dst_bank = d; cfg_base_rd = br; cfg_base_wr = bw; cfg_len = l;
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic watch(input int n, output int nbusy, output int ndone);
        snap_t s;
        snaps.delete();
        nbusy = 0;
        ndone = 0;
        for (int k = 0; k < n; k++) begin
            s = {busy, done, addrh, addrv, chip_enable, write_enable, output_enable};
            snaps.push_back(s);
            if (busy) nbusy++;
            if (done) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_addrh"}, {29'd0, addrh}, 32'd0);
        chk({tag, "_addrv"}, {24'd0, addrv}, 32'd0);
        chk({tag, "_ce"},    {24'd0, chip_enable},   32'hFF);
        chk({tag, "_we"},    {24'd0, write_enable},  32'hFF);
        chk({tag, "_oe"},    {24'd0, output_enable}, 32'hFF);
        chk({tag, "_perf"},  {16'd0, perf_cycles},   32'd0);
    endtask

    initial begin
        int nb;
        int nd;
        logic [AW-1:0] rd_addrs[$];
        logic [AW-1:0] wrap_exp[4];

        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);

        // Single word, src 2 -> dst 5
        start_job(3'd2, 3'd5, 8'h10, 8'h20, 8'd0, 1'b0);
        watch(10, nb, nd);
        chk("t1_rd_addrh", {29'd0, snaps[0].ah}, 32'd2);
        chk("t1_rd_addrv", {24'd0, snaps[0].av}, 32'h10);
        chk("t1_rd_ce",    {24'd0, snaps[0].ce}, 32'hFB);
        chk("t1_rd_oe",    {24'd0, snaps[0].oe}, 32'hFB);
        chk("t1_wait4_ce", {24'd0, snaps[4].ce}, 32'hFF);
        chk("t1_wait4_av", {24'd0, snaps[4].av}, 32'h10);
        chk("t1_wr_addrh", {29'd0, snaps[5].ah}, 32'd5);
        chk("t1_wr_addrv", {24'd0, snaps[5].av}, 32'h20);
        chk("t1_wr_we",    {24'd0, snaps[5].we}, 32'hDF);
        chk("t1_wr_oe",    {24'd0, snaps[5].oe}, 32'hFF);
        chk("t1_busy_cyc", nb, 32'd6);
        chk("t1_done_at6", {31'd0, snaps[6].d}, 32'd1);
        chk("t1_done_cnt", nd, 32'd1);
        chk("t1_perf",     {16'd0, perf_cycles}, PERF_ON ? 32'd6 : 32'd0);

        // Read row wrap-around, src == dst
        start_job(3'd1, 3'd1, 8'hFE, 8'h30, 8'd3, 1'b0);
        watch(30, nb, nd);
        rd_addrs.delete();
        foreach (snaps[k]) if (snaps[k].oe !== 8'hFF) rd_addrs.push_back(snaps[k].av);
        chk("t2_rd_count", rd_addrs.size(), 32'd4);
        for (int k = 0; k < 4 && k < rd_addrs.size(); k++)
            chk($sformatf("t2_rd_addr%0d", k), {24'd0, rd_addrs[k]}, {24'd0, wrap_exp[k]});
        chk("t2_busy_cyc", nb, 32'd24);
        chk("t2_done_cnt", nd, 32'd1);

        // start pulsed in the 2nd WAIT with different cfg is ignored
        start_job(3'd3, 3'd4, 8'h40, 8'h50, 8'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cfg_src_bank = 3'd6; cfg_dst_bank = 3'd7; cfg_base_rd = 8'h90; cfg_base_wr = 8'hA0; cfg_len = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(20, nb, nd);
        chk("t3_busy_rest", nb, 32'd9);
        chk("t3_done_cnt",  nd, 32'd1);
        chk("t3_perf",      {16'd0, perf_cycles}, PERF_ON ? 32'd12 : 32'd0);

        // abort in the WR cycle of word 1 (len=3)
        start_job(3'd0, 3'd6, 8'h60, 8'h70, 8'd3, 1'b0);
        repeat (11) @(negedge clk);
        chk("t4_wr_we",    {24'd0, write_enable}, 32'hBF);
        chk("t4_wr_addrv", {24'd0, addrv}, 32'h71);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_ce",   {24'd0, chip_enable},   32'hFF);
        chk("t4_we",   {24'd0, write_enable},  32'hFF);
        chk("t4_oe",   {24'd0, output_enable}, 32'hFF);
        watch(10, nb, nd);
        chk("t4_no_done", nd, 32'd0);
        chk("t4_no_busy", nb, 32'd0);
        chk("t4_perf",    {16'd0, perf_cycles}, PERF_ON ? 32'd12 : 32'd0);

        // asynchronous reset in the middle of WAIT
        start_job(3'd2, 3'd3, 8'h80, 8'h90, 8'd2, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("t5_async");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_job(3'd1, 3'd2, 8'h00, 8'h00, 8'd0, 1'b0);
        watch(10, nb, nd);
        chk("t5_busy_cyc", nb, 32'd6);
        chk("t5_done_cnt", nd, 32'd1);

        // start and abort together in IDLE: start wins; full 256-word job
        start_job(3'd4, 3'd7, 8'h00, 8'h00, 8'd255, 1'b1);
        watch(1540, nb, nd);
        chk("t6_busy_cyc", nb, 32'd1536);
        chk("t6_done_cnt", nd, 32'd1);
        chk("t6_perf",     {16'd0, perf_cycles}, PERF_ON ? 32'd1536 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
